// File: rtl/lcd_bus_sequencer_if.sv
// ============================================================================
// Module      : lcd_bus_sequencer_if
// Description : Avalon-MM slave bundle for the character-LCD bus sequencer.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface lcd_bus_sequencer_if;
    logic [1:0] address;
    logic       read;
    logic       write;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic       waitrequest;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        input  readdata,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        output readdata,
        output waitrequest
    );
endinterface

`default_nettype wire

// File: rtl/lcd_bus_sequencer.sv
// ============================================================================
// Module      : lcd_bus_sequencer
// Description : Runs one timed HD44780 bus cycle (setup, E pulse, hold,
//               recovery) per Avalon access, stalling the CPU meanwhile.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lcd_bus_sequencer #(
    parameter int unsigned SETUP_CYC   = 4,
    parameter int unsigned PULSE_CYC   = 12,
    parameter int unsigned HOLD_CYC    = 2,
    parameter int unsigned RECOVER_CYC = 25
) (
    input  wire                       clk,
    input  wire                       reset_n,
    lcd_bus_sequencer_if.slave        avs,
    output logic                      LCD_E,
    output logic                      LCD_RS,
    output logic                      LCD_RW,
    inout  wire  [7:0]                LCD_data
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_setup   = 3'd1;
    localparam logic [2:0] c_st_pulse   = 3'd2;
    localparam logic [2:0] c_st_hold    = 3'd3;
    localparam logic [2:0] c_st_recover = 3'd4;

    localparam logic [7:0] c_setup_load   = 8'(SETUP_CYC - 1);
    localparam logic [7:0] c_pulse_load   = 8'(PULSE_CYC - 1);
    localparam logic [7:0] c_hold_load    = 8'(HOLD_CYC - 1);
    localparam logic [7:0] c_recover_load = 8'((RECOVER_CYC == 0) ? 0 : RECOVER_CYC - 1);

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       r_rs;
    logic       r_rw;
    logic       r_e;
    logic       r_drive;
    logic [7:0] r_wdata;
    logic [7:0] r_readdata;

    logic       w_req;
    logic       w_last;
    logic       w_accept;
    logic       w_ack;
    logic       w_rw_nxt;
    logic       w_drive_nxt;

    assign w_req  = avs.read | avs.write;
    assign w_last = (r_cnt == 8'd0);
    assign w_ack  = (r_state == c_st_hold) && w_last;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_last ? r_cnt : r_cnt - 8'd1;
        w_accept    = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_cnt_nxt = 8'd0;
                if (w_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_st_setup;
                    w_cnt_nxt   = c_setup_load;
                end
            end
            c_st_setup: begin
                if (w_last) begin
                    w_state_nxt = c_st_pulse;
                    w_cnt_nxt   = c_pulse_load;
                end
            end
            c_st_pulse: begin
                if (w_last) begin
                    w_state_nxt = c_st_hold;
                    w_cnt_nxt   = c_hold_load;
                end
            end
            c_st_hold: begin
                if (w_last) begin
                    if (RECOVER_CYC == 0) begin
                        w_state_nxt = c_st_idle;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_state_nxt = c_st_recover;
                        w_cnt_nxt   = c_recover_load;
                    end
                end
            end
            c_st_recover: begin
                if (w_last) begin
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = 8'd0;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // A simultaneous read+write is carried out as a write.
    assign w_rw_nxt = w_accept ? (avs.address[0] & ~(avs.read & avs.write)) : r_rw;

    assign w_drive_nxt = ~w_rw_nxt &
                         ((w_state_nxt == c_st_setup) ||
                          (w_state_nxt == c_st_pulse) ||
                          (w_state_nxt == c_st_hold));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_st_idle;
            r_cnt      <= 8'd0;
            r_rs       <= 1'b0;
            r_rw       <= 1'b0;
            r_e        <= 1'b0;
            r_drive    <= 1'b0;
            r_wdata    <= 8'd0;
            r_readdata <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rw    <= w_rw_nxt;
            r_e     <= (w_state_nxt == c_st_pulse);
            r_drive <= w_drive_nxt;
            if (w_accept) begin
                r_rs    <= avs.address[1];
                r_wdata <= avs.writedata;
            end
            // Sample the LCD while E is still high, on the final pulse cycle.
            if ((r_state == c_st_pulse) && w_last && r_rw) begin
                r_readdata <= LCD_data;
            end
        end
    end

    assign avs.waitrequest = w_req & ~w_ack;
    assign avs.readdata    = r_readdata;

    assign LCD_E    = r_e;
    assign LCD_RS   = r_rs;
    assign LCD_RW   = r_rw;
    assign LCD_data = r_drive ? r_wdata : 8'hzz;

endmodule

`default_nettype wire

// File: tb/tb_lcd_bus_sequencer.sv
// ============================================================================
// Module      : tb_lcd_bus_sequencer
// Description : Timeline-model bench for lcd_bus_sequencer, default and
//               minimum-timing instances side by side.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lcd_bus_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] m_read  = 2'b00;
    logic [1:0] m_write = 2'b00;
    logic [1:0] m_addr  [2];
    logic [7:0] m_wdata [2];
    logic [7:0] lcd_val [2];

    logic       e_a, rs_a, rw_a, wait_a, e_b, rs_b, rw_b, wait_b;
    logic [7:0] rd_a, rd_b;
    wire  [7:0] bus_a, bus_b;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_on = 1'b0;

    lcd_bus_sequencer_if ifa ();
    lcd_bus_sequencer_if ifb ();

    assign ifa.read      = m_read[0];
    assign ifa.write     = m_write[0];
    assign ifa.address   = m_addr[0];
    assign ifa.writedata = m_wdata[0];
    assign ifb.read      = m_read[1];
    assign ifb.write     = m_write[1];
    assign ifb.address   = m_addr[1];
    assign ifb.writedata = m_wdata[1];
    assign rd_a   = ifa.readdata;
    assign wait_a = ifa.waitrequest;
    assign rd_b   = ifb.readdata;
    assign wait_b = ifb.waitrequest;

    lcd_bus_sequencer #(.SETUP_CYC(4), .PULSE_CYC(12), .HOLD_CYC(2), .RECOVER_CYC(25)) dut_a (
        .clk(clk), .reset_n(rst_n), .avs(ifa),
        .LCD_E(e_a), .LCD_RS(rs_a), .LCD_RW(rw_a), .LCD_data(bus_a)
    );

    lcd_bus_sequencer #(.SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1), .RECOVER_CYC(0)) dut_b (
        .clk(clk), .reset_n(rst_n), .avs(ifb),
        .LCD_E(e_b), .LCD_RS(rs_b), .LCD_RW(rw_b), .LCD_data(bus_b)
    );

    function automatic int p_s(input int i); return (i == 0) ? 4 : 1;  endfunction
    function automatic int p_p(input int i); return (i == 0) ? 12 : 1; endfunction
    function automatic int p_h(input int i); return (i == 0) ? 2 : 1;  endfunction
    function automatic int p_r(input int i); return (i == 0) ? 25 : 0; endfunction

    // Model: age = cycles since the access was accepted, 0 when idle.
    int         age  [2];
    logic       x_rs [2];
    logic       x_rw [2];
    logic [7:0] x_wd [2];
    logic [7:0] x_rd [2];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                age[i]  <= 0;
                x_rs[i] <= 1'b0;
                x_rw[i] <= 1'b0;
                x_wd[i] <= 8'd0;
                x_rd[i] <= 8'd0;
            end else if (age[i] == 0) begin
                if (m_read[i] | m_write[i]) begin
                    age[i]  <= 1;
                    x_rs[i] <= m_addr[i][1];
                    x_rw[i] <= m_addr[i][0] & ~(m_read[i] & m_write[i]);
                    x_wd[i] <= m_wdata[i];
                end
            end else begin
                if ((age[i] == p_s(i) + p_p(i)) && x_rw[i]) x_rd[i] <= lcd_val[i];
                age[i] <= (age[i] >= p_s(i) + p_p(i) + p_h(i) + p_r(i)) ? 0 : age[i] + 1;
            end
        end
    end

    function automatic logic dut_drives(input int i);
        return (age[i] >= 1) && (age[i] <= p_s(i) + p_p(i) + p_h(i)) && !x_rw[i];
    endfunction

    function automatic logic [7:0] expect_sig(input int i, input int s);
        logic ack;
        logic pulse;
        ack   = (age[i] == p_s(i) + p_p(i) + p_h(i));
        pulse = (age[i] > p_s(i)) && (age[i] <= p_s(i) + p_p(i));
        case (s)
            0:       return {7'd0, (m_read[i] | m_write[i]) & ~ack};
            1:       return {7'd0, pulse};
            2:       return {7'd0, x_rs[i]};
            3:       return {7'd0, x_rw[i]};
            4:       return dut_drives(i) ? x_wd[i] : lcd_val[i];
            default: return x_rd[i];
        endcase
    endfunction

    function automatic logic [7:0] obs(input int i, input int s);
        if (i == 0) begin
            case (s)
                0:       return {7'd0, wait_a};
                1:       return {7'd0, e_a};
                2:       return {7'd0, rs_a};
                3:       return {7'd0, rw_a};
                4:       return bus_a;
                default: return rd_a;
            endcase
        end
        case (s)
            0:       return {7'd0, wait_b};
            1:       return {7'd0, e_b};
            2:       return {7'd0, rs_b};
            3:       return {7'd0, rw_b};
            4:       return bus_b;
            default: return rd_b;
        endcase
    endfunction

    function automatic string sname(input int s);
        case (s)
            0:       return "waitrequest";
            1:       return "LCD_E";
            2:       return "LCD_RS";
            3:       return "LCD_RW";
            4:       return "LCD_data";
            default: return "readdata";
        endcase
    endfunction

    // The LCD side drives the bus whenever the sequencer must not.
    logic [1:0] x_drv;
    always_comb begin
        x_drv = 2'b00;
        for (int i = 0; i < 2; i++) x_drv[i] = dut_drives(i);
    end
    assign bus_a = x_drv[0] ? 8'hzz : lcd_val[0];
    assign bus_b = x_drv[1] ? 8'hzz : lcd_val[1];

    task automatic check(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s dut%0d t=%0t: got %h, want %h", nm, i, $time, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                for (int s = 0; s < 6; s++) check(sname(s), i, obs(i, s), expect_sig(i, s));
            end
        end
    end

    // Issues one access on instance i and holds it until the ack cycle ends.
    task automatic access(input int i, input logic rd, input logic wr, input logic [1:0] ad,
                          input logic [7:0] wd, output int lat, output int e_first,
                          output int e_len, output logic [7:0] bus_e, output logic [7:0] rw_e,
                          output logic [7:0] rd_ack);
        int n;
        m_read[i]  = rd;
        m_write[i] = wr;
        m_addr[i]  = ad;
        m_wdata[i] = wd;
        lat = -1; e_first = -1; e_len = 0; bus_e = 8'd0; rw_e = 8'd0; rd_ack = 8'd0; n = 0;
        while (lat < 0 && n < 200) begin
            @(negedge clk);
            if (obs(i, 1) == 8'd1) begin
                if (e_first < 0) begin
                    e_first = n;
                    bus_e   = obs(i, 4);
                    rw_e    = obs(i, 3);
                end
                e_len++;
            end
            if (obs(i, 0) == 8'd0) begin
                lat    = n;
                rd_ack = obs(i, 5);
            end
            n++;
        end
        if (lat < 0) check_int("ack_timeout", n, -1);
        @(posedge clk); #1;
        m_read[i]  = 1'b0;
        m_write[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, ef, el, lat2, ef2, el2, cnt, n;
        logic [7:0] be, rwe, rda;

        for (int i = 0; i < 2; i++) begin
            m_addr[i]  = 2'b00;
            m_wdata[i] = 8'h00;
            lcd_val[i] = 8'h00;
        end
        @(posedge clk); #1;
        chk_on = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Reset state
        check("rst_E", 0, {7'd0, e_a}, 8'd0);
        check("rst_RS", 0, {7'd0, rs_a}, 8'd0);
        check("rst_RW", 0, {7'd0, rw_a}, 8'd0);
        check("rst_readdata", 0, rd_a, 8'd0);
        check("rst_wait", 0, {7'd0, wait_a}, 8'd0);

        // Data write 0x41
        access(0, 1'b0, 1'b1, 2'b10, 8'h41, lat, ef, el, be, rwe, rda);
        check_int("wr_latency", lat, 18);
        check_int("wr_E_start", ef, 5);
        check_int("wr_E_len", el, 12);
        check("wr_bus_at_E", 0, be, 8'h41);
        check("wr_RS_after", 0, {7'd0, rs_a}, 8'd1);
        idle(30);

        // Read, LCD returns 0x80; writedata is junk that must never reach the bus
        lcd_val[0] = 8'h80;
        access(0, 1'b1, 1'b0, 2'b01, 8'h7F, lat, ef, el, be, rwe, rda);
        check_int("rd_latency", lat, 18);
        check("rd_readdata_ack", 0, rda, 8'h80);
        check("rd_RW_at_E", 0, rwe, 8'd1);
        idle(30);
        lcd_val[0] = 8'h00;

        // Back-to-back writes
        access(0, 1'b0, 1'b1, 2'b00, 8'h01, lat, ef, el, be, rwe, rda);
        access(0, 1'b0, 1'b1, 2'b00, 8'h0C, lat2, ef2, el2, be, rwe, rda);
        check_int("b2b_first_lat", lat, 18);
        check_int("b2b_second_lat", lat2, 43);
        check_int("b2b_E_spacing", (lat + 1) + ef2 - ef, 44);
        check("b2b_bus_at_E", 0, be, 8'h0C);
        readdata_hold: check("readdata_hold", 0, rd_a, 8'h80);
        idle(30);

        // read and write together behave as a write
        access(0, 1'b1, 1'b1, 2'b00, 8'h38, lat, ef, el, be, rwe, rda);
        check("rw_both_RW", 0, rwe, 8'd0);
        check("rw_both_bus", 0, be, 8'h38);
        idle(30);

        // Minimum timing instance
        access(1, 1'b0, 1'b1, 2'b11, 8'hA7, lat, ef, el, be, rwe, rda);
        access(1, 1'b0, 1'b1, 2'b10, 8'h5C, lat2, ef2, el2, be, rwe, rda);
        check_int("min_latency", lat, 3);
        check_int("min_latency2", lat2, 3);
        check_int("min_E_len", el2, 1);
        check_int("min_E_spacing", (lat + 1) + ef2 - ef, 4);
        check("min_bus_at_E", 1, be, 8'h5C);
        idle(4);

        // Reset asserted in the 6th PULSE cycle
        m_addr[0]  = 2'b10;
        m_wdata[0] = 8'h55;
        m_write[0] = 1'b1;
        cnt = 0;
        n   = 0;
        while (cnt < 6 && n < 100) begin
            @(negedge clk);
            if (e_a) cnt++;
            n++;
        end
        check_int("pulse_reach", cnt, 6);
        #2;
        rst_n      = 1'b0;
        m_write[0] = 1'b0;
        #1;
        check("mid_rst_E", 0, {7'd0, e_a}, 8'd0);
        check("mid_rst_bus", 0, bus_a, 8'h00);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        access(0, 1'b0, 1'b1, 2'b10, 8'h55, lat, ef, el, be, rwe, rda);
        check_int("post_rst_latency", lat, 18);
        check_int("post_rst_E_len", el, 12);
        check("post_rst_bus", 0, be, 8'h55);
        idle(30);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
